// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream and writes it into the instruction memory.
// The core is held in reset until a frame with a good checksum has been written.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              wea,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   output logic              core_nrst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // state    | meaning
   // S_IDLE   | after reset, waiting for start
   // S_LEN_HI | waiting for word count high byte
   // S_LEN_LO | waiting for word count low byte, range check
   // S_DATA   | packing bytes into words and writing them
   // S_CHECK  | waiting for the checksum byte
   // S_DONE   | load good, core released
   // S_ERROR  | bad length or checksum
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   localparam int IDX_W = ADDR_W + 1;

   logic [2:0]        state_q,    state_d;
   logic [7:0]        len_hi_q,   len_hi_d;
   logic [IDX_W-1:0]  len_q,      len_d;
   logic [IDX_W-1:0]  idx_q,      idx_d;
   logic [1:0]        bcnt_q,     bcnt_d;
   logic [7:0]        csum_q,     csum_d;
   logic [23:0]       word_q,     word_d;
   logic              wea_q,      wea_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [DATA_W-1:0] din_q,      din_d;
   logic              rx_ready_q, rx_ready_d;

   logic        accept;
   logic [15:0] len_full;

   assign accept   = rx_valid & rx_ready_q;
   assign len_full = {len_hi_q, rx_data};

   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      len_d    = len_q;
      idx_d    = idx_q;
      bcnt_d   = bcnt_q;
      csum_d   = csum_q;
      word_d   = word_q;
      wea_d    = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               idx_d   = '0;
               bcnt_d  = '0;
               csum_d  = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = rx_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = len_full[IDX_W-1:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q + rx_data;
               word_d = {word_q[15:0], rx_data};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  // the write lands on the cycle after the 4th byte
                  wea_d  = 1'b1;
                  addr_d = idx_q[ADDR_W-1:0];
                  din_d  = {word_q, rx_data};
                  idx_d  = idx_q + 1'b1;
                  if (idx_q == len_q - 1'b1) state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                       (state_d == S_DATA)   || (state_d == S_CHECK);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         len_hi_q   <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         csum_q     <= '0;
         word_q     <= '0;
         wea_q      <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         rx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_hi_q   <= len_hi_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         csum_q     <= csum_d;
         word_q     <= word_d;
         wea_q      <= wea_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign wea       = wea_q;
   assign addr      = addr_q;
   assign din       = din_q;
   assign busy      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERROR);
   assign core_nrst = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus stall, restart, reset and full-size sequences.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wea;
   logic [9:0]  addr;
   logic [31:0] din;
   logic        core_nrst;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader dut (
      .clk(clk), .nrst(nrst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .wea(wea), .addr(addr), .din(din), .core_nrst(core_nrst),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [9:0]  wr_a[$];
   logic [31:0] wr_d[$];

   always @(negedge clk) begin
      if (wea === 1'b1) begin
         wr_a.push_back(addr);
         wr_d.push_back(din);
      end
   end

   typedef struct {
      int          nb;
      logic [87:0] bytes;
      logic        exp_done;
      logic        exp_err;
      int          exp_nwr;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t vec [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (rx_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual rx_ready=%b required=1", rx_ready);
      end else begin
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
   endtask

   task automatic send_bytes(input logic [87:0] bytes, input int nb);
      for (int i = 0; i < nb; i++) send(bytes[87-8*i -: 8]);
   endtask

   task automatic chk_end(input string nm, input logic exp_done, input logic exp_err);
      chk({nm, "_done"},      32'(done),      32'(exp_done));
      chk({nm, "_err"},       32'(err),       32'(exp_err));
      chk({nm, "_core_nrst"}, 32'(core_nrst), 32'(exp_done));
      chk({nm, "_rx_ready"},  32'(rx_ready),  32'd0);
      chk({nm, "_busy"},      32'(busy),      32'd0);
   endtask

   task automatic chk_two_words(input string nm);
      chk({nm, "_nwr"}, 32'(wr_a.size()), 32'd2);
      if (wr_a.size() >= 2) begin
         chk({nm, "_a0"}, 32'(wr_a[0]), 32'd0);
         chk({nm, "_d0"}, wr_d[0], 32'h12345678);
         chk({nm, "_a1"}, 32'(wr_a[1]), 32'd1);
         chk({nm, "_d1"}, wr_d[1], 32'hDEADBEEF);
      end
   endtask

   function automatic logic [7:0] big_byte(input int k);
      return 8'((k * 7 + 3) & 255);
   endfunction

   localparam logic [87:0] GOOD = 88'h0002_12345678_DEADBEEF_4C;

   initial begin
      logic [7:0]  sum;
      logic [31:0] w;
      int          errs;

      vec[0] = '{11, GOOD,                            1'b1, 1'b0, 2, 32'h12345678, 32'hDEADBEEF};
      vec[1] = '{11, 88'h0002_12345678_DEADBEEF_4D,   1'b0, 1'b1, 2, 32'h12345678, 32'hDEADBEEF};
      vec[2] = '{2,  88'h0000_00000000_00000000_00,   1'b0, 1'b1, 0, 32'h0,        32'h0};
      vec[3] = '{2,  88'h0401_00000000_00000000_00,   1'b0, 1'b1, 0, 32'h0,        32'h0};
      vec[4] = '{7,  88'h0001_00000001_01_00000000,   1'b1, 1'b0, 1, 32'h00000001, 32'h0};

      nrst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      #2;
      chk("rst_async_wea", 32'(wea), 32'd0);
      tick(); tick();
      chk("rst_rx_ready",  32'(rx_ready),  32'd0);
      chk("rst_core_nrst", 32'(core_nrst), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done_err",  32'({done, err}), 32'd0);
      chk("rst_addr_din",  32'(addr) | din, 32'd0);
      nrst = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         pulse_start();
         chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
         clear_log();
         send_bytes(vec[v].bytes, vec[v].nb);
         chk_end(nm, vec[v].exp_done, vec[v].exp_err);
         tick(); tick();
         chk({nm, "_nwr"}, 32'(wr_a.size()), 32'(vec[v].exp_nwr));
         if (vec[v].exp_nwr >= 1 && wr_a.size() >= 1) begin
            chk({nm, "_a0"}, 32'(wr_a[0]), 32'd0);
            chk({nm, "_d0"}, wr_d[0], vec[v].w0);
         end
         if (vec[v].exp_nwr >= 2 && wr_a.size() >= 2) begin
            chk({nm, "_a1"}, 32'(wr_a[1]), 32'd1);
            chk({nm, "_d1"}, wr_d[1], vec[v].w1);
         end
      end

      // stall mid-word
      pulse_start();
      clear_log();
      send_bytes(GOOD, 4);
      repeat (5) tick();
      chk("stall_no_early_wea", 32'(wr_a.size()), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      for (int i = 4; i < 11; i++) send(GOOD[87-8*i -: 8]);
      chk_end("stall", 1'b1, 1'b0);
      chk_two_words("stall");

      // start while in DATA is ignored
      pulse_start();
      clear_log();
      send_bytes(GOOD, 4);
      pulse_start();
      chk("data_start_busy", 32'(busy), 32'd1);
      for (int i = 4; i < 11; i++) send(GOOD[87-8*i -: 8]);
      chk_end("data_start", 1'b1, 1'b0);
      chk_two_words("data_start");

      // restart from DONE
      chk("done_core_before", 32'(core_nrst), 32'd1);
      pulse_start();
      chk("restart_core_nrst", 32'(core_nrst), 32'd0);
      chk("restart_busy",      32'(busy),      32'd1);
      chk("restart_done",      32'(done),      32'd0);
      clear_log();
      send_bytes(vec[4].bytes, 7);
      chk_end("restart", 1'b1, 1'b0);
      chk("restart_nwr", 32'(wr_a.size()), 32'd1);
      if (wr_a.size() >= 1) begin
         chk("restart_a0", 32'(wr_a[0]), 32'd0);
         chk("restart_d0", wr_d[0], 32'h00000001);
      end

      // full-size load, N = 1024
      pulse_start();
      clear_log();
      send(8'h04);
      send(8'h00);
      sum = 8'h00;
      for (int k = 0; k < 4096; k++) begin
         sum = sum + big_byte(k);
         send(big_byte(k));
      end
      send(sum);
      chk_end("big", 1'b1, 1'b0);
      chk("big_nwr", 32'(wr_a.size()), 32'd1024);
      errs = 0;
      for (int i = 0; i < wr_a.size() && i < 1024; i++) begin
         w = {big_byte(4*i), big_byte(4*i+1), big_byte(4*i+2), big_byte(4*i+3)};
         if (wr_a[i] !== 10'(i) || wr_d[i] !== w) errs++;
      end
      chk("big_contents", 32'(errs), 32'd0);
      if (wr_a.size() == 1024) chk("big_last_addr", 32'(wr_a[1023]), 32'h3FF);

      // async reset mid-load
      pulse_start();
      clear_log();
      send_bytes(GOOD, 8);
      chk("midrst_din_before", din, 32'h12345678);
      #3;
      nrst = 1'b0;
      #1;
      chk("midrst_wea",       32'(wea),       32'd0);
      chk("midrst_addr",      32'(addr),      32'd0);
      chk("midrst_din",       din,            32'd0);
      chk("midrst_rx_ready",  32'(rx_ready),  32'd0);
      chk("midrst_busy",      32'(busy),      32'd0);
      chk("midrst_core_nrst", 32'(core_nrst), 32'd0);
      chk("midrst_done_err",  32'({done, err}), 32'd0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      tick();
      pulse_start();
      clear_log();
      send_bytes(GOOD, 11);
      chk_end("after_rst", 1'b1, 1'b0);
      chk_two_words("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory, driving the same port set the core reads through: wea, 10-bit addr, 32-bit din.
- Consumes a framed byte stream over a valid/ready handshake, normally from a UART receiver. Frame: 16-bit word count, the program words, one checksum byte.
- Packs bytes into words and writes them to consecutive addresses from 0.
- Holds the core in reset until a load completes with a good checksum.

Parameters:
ADDR_W, 10, instruction memory address width (word addressed)
DATA_W, 32, instruction word width (fixed at 4 bytes)
MAX_WORDS, 1024, largest accepted word count (2**ADDR_W)

Ports:
clk  input  1  system clock, all state on rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse to begin a load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
wea  output  1  instruction memory write enable
addr  output  ADDR_W  instruction memory word address
din  output  DATA_W  instruction memory write data
core_nrst  output  1  active-low reset to the core
busy  output  1  load in progress
done  output  1  last load succeeded
err  output  1  last load failed

Behaviour:
- Reset (async, nrst=0): state IDLE. wea=0, addr=0, din=0, rx_ready=0, core_nrst=0, busy=0, done=0, err=0. Word index, byte counter and checksum accumulator cleared. Asserting nrst mid-load aborts at once; wea drops without waiting for a clock.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- A byte is accepted only on a cycle where rx_valid=1 and rx_ready=1.
- rx_ready is registered: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise.
- IDLE/DONE/ERROR, start=1 -> LEN_HI. On entry, clear index, byte counter, checksum, done and err.
- start is ignored in all other states.
- LEN_HI: accepted byte -> N[15:8], go to LEN_LO.
- LEN_LO: accepted byte -> N[7:0].
  - N=0 or N>MAX_WORDS -> ERROR.
  - Otherwise -> DATA.
- DATA: bytes arrive big-endian (first byte -> din[31:24]).
  - Every accepted byte is added to the 8-bit checksum, mod 256.
  - On the 4th byte of a word, the next cycle drives wea=1 for exactly one cycle, with addr=word index and din=assembled word. The index then increments.
  - wea is 0 on all other cycles. addr and din hold their last values.
  - After word N-1 is accepted, go to CHECK. Its write still occurs on the following cycle.
- CHECK: accepted byte compared with the checksum.
  - Equal -> DONE.
  - Not equal -> ERROR.
- Checksum covers data bytes only, not the length bytes.
- Outputs by state:
  - busy=1 in LEN_HI through CHECK.
  - done=1 only in DONE; err=1 only in ERROR.
  - core_nrst=1 only in DONE, asserted the cycle DONE is entered. Dropping to 0 on leaving DONE takes one cycle.
- Word writes never wrap. N<=MAX_WORDS guarantees the highest address is MAX_WORDS-1.
- rx_valid without a matching rx_ready is ignored, and the byte is not consumed.
- Stalls: rx_valid may go low mid-word for any number of cycles. Partial-word state is preserved.
- No timeout. A stalled stream leaves busy=1 until nrst or a completed frame.

Test Plan:
- Good 2-word load: start; bytes 00 02 12 34 56 78 DE AD BE EF 4C.
  - Writes addr0=0x12345678 and addr1=0xDEADBEEF, one wea cycle each.
  - Ends in done=1, core_nrst=1, err=0, rx_ready=0.
- Bad checksum: same frame with checksum 4D.
  - Both writes still occur.
  - Ends in err=1, done=0, core_nrst=0.
- Length bounds:
  - N=0x0000 -> err=1 right after the 2nd byte, no wea.
  - N=0x0401 -> err=1, no wea.
  - N=0x0400 with 4096 data bytes and a correct checksum -> last write at addr=0x3FF, done=1.
- Handshake stalls: drive rx_valid=0 for 5 cycles between bytes 2 and 3 of word 0.
  - Same writes and result as the good 2-word load.
  - No byte duplicated or dropped.
  - wea never asserted early.
- Reset mid-load: assert nrst=0 after 6 data bytes.
  - All outputs take reset values without a clock edge.
  - A new start plus a full good frame then loads correctly from addr 0.
- Restart and ignore:
  - start during DATA has no effect.
  - start in DONE drops core_nrst to 0 next cycle and returns busy=1.
  - A second good frame (N=1, 00 00 00 01, checksum 01) writes addr0=0x00000001 and ends in done=1.
